// File: rtl/floo_pkg.sv
// Shared link types for the floo VC router: header layout, flit layout and
// the debug-only cause code for the receive-port protocol error flag.
package floo_pkg;

    typedef enum logic [2:0] {
        North,
        East,
        South,
        West,
        Eject
    } route_direction_e;

    // vc_id is wider than log2(NumVC) so an out-of-range id is representable.
    typedef struct packed {
        logic [2:0]       vc_id;
        logic             lookahead;
        logic             last;
        route_direction_e dir;
        logic [3:0]       dst_id;
    } hdr_t;

    typedef struct packed {
        hdr_t       hdr;
        logic [7:0] payload;
    } flit_t;

    typedef enum logic [2:0] {
        ErrNone,
        ErrOverflow,
        ErrUnderflow,
        ErrIllegalVc,
        ErrBadPop
    } err_cause_e;

endpackage

// File: rtl/floo_vc_rx_fifo.sv
// Single-VC flit FIFO: non-power-of-two depth, head read straight from
// storage, simultaneous push/pop allowed when full.
module floo_vc_rx_fifo #(
    parameter int unsigned Depth  = 3,
    parameter type         flit_t = logic,
    localparam int unsigned CntW  = $clog2(Depth + 1),
    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push,
    input  logic            pop,
    input  flit_t           data,
    output flit_t           head,
    output logic [CntW-1:0] count,
    output logic            full,
    output logic            empty
);

    flit_t            mem [Depth];
    logic [PtrW-1:0]  rptr_q;
    logic [PtrW-1:0]  wptr_q;
    logic [CntW-1:0]  count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rptr_q];
    assign count   = count_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wptr_q] <= data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (pop_ok) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/floo_vc_rx_port.sv
// Receive side of a VC link: demuxes incoming flits into per-VC FIFOs,
// exposes each head, and returns one credit upstream per accepted pop.
module floo_vc_rx_port #(
    parameter int unsigned NumVC          = 4,
    parameter int unsigned VCDepth        = 3,
    parameter type         flit_t         = floo_pkg::flit_t,
    parameter type         hdr_t          = floo_pkg::hdr_t,
    parameter int unsigned NumVCWidth     = (NumVC > 1) ? $clog2(NumVC) : 1,
    parameter type         flit_payload_t = logic [$bits(flit_t)-$bits(hdr_t)-1:0]
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            valid_i,
    input  flit_t                           data_i,
    output logic [NumVC-1:0]                vc_valid_o,
    output hdr_t          [NumVC-1:0]       vc_ctrl_head_o,
    output flit_payload_t [NumVC-1:0]       vc_data_head_o,
    input  logic                            read_valid_i,
    input  logic [NumVC-1:0]                read_vc_id_oh_i,
    output logic                            credit_valid_o,
    output logic [NumVCWidth-1:0]           credit_id_o,
    output logic                            err_o
);

    import floo_pkg::*;

    localparam int unsigned CntW = $clog2(VCDepth + 1);

    logic [NumVC-1:0]      push_vc;
    logic [NumVC-1:0]      pop_req;
    logic [NumVC-1:0]      push_eff;
    logic [NumVC-1:0]      pop_eff;
    logic [NumVC-1:0]      full;
    logic [NumVC-1:0]      empty;
    logic [CntW-1:0]       cnt [NumVC];
    flit_t                 head [NumVC];
    logic                  pop_legal;
    logic                  vc_illegal;
    err_cause_e            err_cause;
    logic                  credit_vld_p1;
    logic [NumVCWidth-1:0] credit_id_p1;
    logic                  err_q;

    function automatic logic [NumVCWidth-1:0] oh2bin(input logic [NumVC-1:0] oh);
        logic [NumVCWidth-1:0] bin;
        bin = '0;
        for (int i = 0; i < NumVC; i++) begin
            if (oh[i]) bin = NumVCWidth'(i);
        end
        return bin;
    endfunction

    always_comb begin
        pop_legal  = read_valid_i && $onehot(read_vc_id_oh_i);
        vc_illegal = valid_i && (32'(data_i.hdr.vc_id) >= NumVC);
        for (int k = 0; k < NumVC; k++) begin
            push_vc[k] = valid_i && (32'(data_i.hdr.vc_id) == 32'(k));
            pop_req[k] = pop_legal && read_vc_id_oh_i[k];
        end
    end

    assign pop_eff  = pop_req & ~empty;
    assign push_eff = push_vc & (~full | pop_eff);

    for (genvar k = 0; k < NumVC; k++) begin : g_vc
        floo_vc_rx_fifo #(
            .Depth  (VCDepth),
            .flit_t (flit_t)
        ) i_fifo (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .push  (push_eff[k]),
            .pop   (pop_eff[k]),
            .data  (data_i),
            .head  (head[k]),
            .count (cnt[k]),
            .full  (full[k]),
            .empty (empty[k])
        );

        assign vc_valid_o[k]     = (cnt[k] != '0);
        assign vc_ctrl_head_o[k] = head[k].hdr;
        assign vc_data_head_o[k] = head[k].payload;
    end

    // Only one cause is named when several coincide; the flag itself is what matters.
    always_comb begin
        err_cause = ErrNone;
        if (vc_illegal) begin
            err_cause = ErrIllegalVc;
        end else if (read_valid_i && !pop_legal) begin
            err_cause = ErrBadPop;
        end else if (|(pop_req & empty)) begin
            err_cause = ErrUnderflow;
        end else if (|(push_vc & full & ~pop_eff)) begin
            err_cause = ErrOverflow;
        end
    end

    // Stage p1: credit return and sticky error, registered off the pop decode.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credit_vld_p1 <= 1'b0;
            credit_id_p1  <= '0;
            err_q         <= 1'b0;
        end else begin
            credit_vld_p1 <= |pop_eff;
            credit_id_p1  <= oh2bin(pop_eff);
            if (err_cause != ErrNone) begin
                err_q <= 1'b1;
            end
        end
    end

    assign credit_valid_o = credit_vld_p1;
    assign credit_id_o    = credit_id_p1;
    assign err_o          = err_q;

endmodule

// File: doc/floo_vc_rx_port.md
# floo_vc_rx_port

Receive side of a virtual-channel link: accepts one flit per cycle from the upstream router's switch output, steers it by `hdr.vc_id` into a per-VC FIFO, and presents each VC's head flit (split into header and payload) to the local VC allocator and switch. On every pop it returns one credit per VC to the upstream transmitter. It sits between the link input and the VC-select/switch stage of each input port of the VC router.

## Interface
- `NumVC`, 4, number of virtual channels on this input port (1..8).
- `VCDepth`, 3, flit entries per VC FIFO (>=1); the upstream credit counter is initialised to this value.
- `flit_t`, logic, link flit type; contains `hdr` of type `hdr_t` and `payload`.
- `hdr_t`, logic, header type; contains `vc_id`, `lookahead`, `last` and routing fields.
- `NumVCWidth`, max(1,$clog2(NumVC)), derived; do not override.
- `flit_payload_t`, derived, `logic[$bits(flit_t)-$bits(hdr_t)-1:0]`.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `valid_i`  in  1  flit on `data_i` is valid. There is no ready signal: the upstream transmitter holds a credit for every flit it sends.
- `data_i`  in  flit_t  incoming flit.
- `vc_valid_o`  out  NumVC  VC FIFO non-empty.
- `vc_ctrl_head_o`  out  NumVC x hdr_t  head header per VC.
- `vc_data_head_o`  out  NumVC x flit_payload_t  head payload per VC.
- `read_valid_i`  in  1  pop request from the switch stage.
- `read_vc_id_oh_i`  in  NumVC  one-hot VC to pop.
- `credit_valid_o`  out  1  one credit returned upstream.
- `credit_id_o`  out  NumVCWidth  VC of the returned credit.
- `err_o`  out  1  sticky protocol error: overflow, underflow, illegal vc_id or non-one-hot pop.

## Operation
- **Push.** When `valid_i` is high, the flit goes to FIFO `data_i.hdr.vc_id`. The whole flit is stored unchanged, including `lookahead` and `last`.
- **Illegal vc_id.** If `vc_id >= NumVC`, the flit is dropped and `err_o` is set.
- **Push to a full VC.**
  - If `count == VCDepth` and there is no pop of the same VC in the same cycle, the flit is dropped and `err_o` is set.
  - If a pop of the same VC happens in the same cycle, the push is accepted and the count is unchanged.
- **Pop.** When `read_valid_i` is high and `read_vc_id_oh_i` is one-hot, the selected FIFO's head is removed.
  - Pop of an empty VC: ignored, `err_o` set.
  - `read_vc_id_oh_i` zero or multi-hot while `read_valid_i` is high: no pop, `err_o` set.
- **Credit return.** Every accepted pop of VC k produces `credit_valid_o=1, credit_id_o=k` in the following cycle. At most one pop per cycle, so at most one credit per cycle.
- **Independence.** Push and pop of different VCs in the same cycle are independent.
- **Counters.** Per-VC count is NumVCWidth-independent: `$clog2(VCDepth+1)` bits. Read/write pointers wrap modulo `VCDepth`; `VCDepth` need not be a power of 2.
- **Head outputs.** Driven directly from FIFO storage at the read pointer.
  - When `vc_valid_o[k]=0`, the head outputs are don't-care.
  - The bench checks them only while valid.
- **Error flag.** `err_o` is cleared only by reset.

## Timing
- **Reset values.** All counts and pointers are 0. `vc_valid_o=0`, `credit_valid_o=0`, `credit_id_o=0`, `err_o=0`. Storage is not reset.
- **Reset mid-operation.** Reset discards all buffered flits and any pending credit. No credit is emitted in the cycle after reset deassertion.
- **Push latency.** A flit pushed in cycle t makes `vc_valid_o` high and appears on the head outputs in cycle t+1. There is no combinational bypass from `data_i`.
- **Pop latency.** A pop in cycle t removes the head at the clock edge. The next entry is visible in t+1. `credit_valid_o` is asserted in t+1 for exactly one cycle per pop.
- **Full-throughput round trip.** Push in t, pop in t+1, credit in t+2. This gives the upstream a round trip that sustains full throughput with `VCDepth>=3`.
- **Inputs to outputs.** No combinational path from any input to any output; `credit_*` is registered.
- **Single-VC push/pop.** Simultaneous push and pop on the same VC holding 1 entry: the old head leaves and the new flit becomes head in t+1; `vc_valid_o` stays high.

## Structure
- Shared constants and types (`route_direction_e`, `hdr_t` field layout) come from `floo_pkg`. No new package entries except an `err` cause enum, which is for debug only.
- One sub-module: `floo_vc_rx_fifo`, a single-VC FIFO with sync active-high reset and params `Depth` and `flit_t`.
  - Inputs: `push`, `pop`.
  - Outputs: `head`, `count`, `full`, `empty`.
  - Instantiated NumVC times.
- The top level contains the vc_id demux, the pop decode, error logic and the credit register.

## Test plan
- **Reset, push and head.** Reset, then push flit vc_id=2, payload=0xA5 in cycle 1 -> cycle 2 `vc_valid_o=4'b0100`, `vc_data_head_o[2]=0xA5`; `credit_valid_o` stays 0.
- **Pop and credit.** Fill VC1 with 3 flits (payloads 1,2,3), then pop VC1 in three consecutive cycles -> heads seen in order 1,2,3. `credit_valid_o=1, credit_id_o=1` for 3 consecutive cycles, each one cycle after its pop. `vc_valid_o[1]=0` afterwards.
- **Full-FIFO simultaneous push/pop.** VC0 full (3 entries), push vc_id=0 and pop VC0 in the same cycle -> no error, count stays 3, new flit is last in order.
- **Overflow.** VC0 full and pushed without a pop -> `err_o=1` from the next cycle and sticky; FIFO contents unchanged.
- **Cross-VC traffic.** Interleaved pushes to VC0/VC3 with a pop of VC3 in the same cycle as a push to VC0 -> both FIFOs are correct and the credit reports id 3. `vc_id=5` with NumVC=4 -> flit dropped, `err_o=1`.
- **Reset mid-operation.** Assert reset with 2 flits buffered and a pop in the previous cycle -> next cycle all outputs are 0, including the pending credit.
